pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised inter-stage pipeline register for the MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Replaces the write-enable latch with a valid/ready handshake and a 2-entry skid buffer,
//  so stalls do not need combinational back-pressure.
//  Flush and bad-instruction squash zero only the side-effect control bits: reg/cp0 write
//  enables, mem_wen, jump and branch fields. Payload is carried unchanged.
// PARAMETERS
//  DATA_W   64  payload width (pc, buses, imm, etc., concatenated by instantiator)
//  CTRL_W   16  side-effect control width; zeroed on squash
//  CNT_W    8   width of saturating squash counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-low reset
//  in_valid     in   1        upstream beat present
//  in_ready     out  1        buffer can accept (registered)
//  in_data      in   DATA_W   upstream payload
//  in_ctrl      in   CTRL_W   upstream side-effect controls
//  in_bad       in   1        upstream beat is a bad/illegal instruction
//  flush        in   1        kill all held and incoming beats this cycle
//  out_valid    out  1        downstream beat present
//  out_ready    in   1        downstream accepts
//  out_data     out  DATA_W   head payload
//  out_ctrl     out  CTRL_W   head controls (already masked)
//  out_bad      out  1        head beat flagged bad
//  occupancy    out  2        entries held: 0, 1 or 2
//  squash_cnt   out  CNT_W    saturating count of beats discarded by flush
// BEHAVIOUR
//  - Reset (rst=0, async): state EMPTY; out_valid=0, in_ready=1, occupancy=0, squash_cnt=0.
//    out_data, out_ctrl and out_bad are 0.
//  - Storage: head (H) and skid (S) registers. FIFO order is strict.
//    out_* always show H. push = in_valid&in_ready&!flush. pop = out_valid&out_ready.
//  - States and transitions (no flush):
//    EMPTY: push -> ONE (H<=in). Latency in->out is 1 cycle.
//    ONE: push&pop -> ONE (H<=in). push only -> TWO (S<=in). pop only -> EMPTY.
//    TWO: pop -> ONE (H<=S). No push is possible because in_ready=0.
//  - in_ready is registered and equals (next_state != TWO). No comb path from out_ready.
//  - Masking on push: stored ctrl = in_bad ? 0 : in_ctrl. Stored bad = in_bad.
//  - flush=1: next state EMPTY, out_valid=0 the next cycle, and in_ready=1 the next cycle.
//    Any in_valid beat that cycle is dropped even if in_ready=1.
//    A pop that coincides with flush still completes downstream.
//    Flush overrides push and pop for state purposes.
//  - squash_cnt increments by the number of discarded beats:
//    held entries not popped that cycle, plus 1 if in_valid&in_ready. Range 0..3.
//    It saturates at 2^CNT_W-1 and never wraps.
//  - occupancy is 0/1/2 for EMPTY/ONE/TWO and is registered.
//  - Reset asserted mid-transfer clears everything immediately. No beat survives.
// TESTING
//  1. Reset, then push D=0x11 with out_ready=1 -> out_valid=1, out_data=0x11 next cycle;
//     occupancy=1.
//  2. Hold out_ready=0 and push 0x21, 0x22 -> occupancy=2, in_ready=0.
//     Then out_ready=1 -> 0x21, then 0x22, in order.
//  3. Push with in_bad=1, in_ctrl=0xFFFF -> out_bad=1, out_ctrl=0x0000, out_data unchanged.
//  4. In TWO, flush=1 with in_valid=1, out_ready=0 -> next cycle out_valid=0, in_ready=1,
//     squash_cnt +=2.
//  5. Set squash_cnt to 0xFE, then flush with 2 held and 1 incoming -> squash_cnt=0xFF,
//     not 0x01.
//  6. Assert rst low mid-stream with occupancy=2 -> outputs zero asynchronously, before the
//     next clk edge.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake and 2-entry skid.
// Squash (flush or bad beat) clears side-effect controls; payload passes through.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_bad,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_bad,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  squash_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              s_bad;

  logic              push;
  logic              pop;
  logic [CTRL_W-1:0] in_ctrl_m;
  logic [1:0]        held_left;
  logic [1:0]        drop_in;
  logic [2:0]        squash_inc;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_nx;

  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign in_ctrl_m = in_bad ? '0 : in_ctrl;

  // Beats lost on a flush: held entries not leaving, plus an accepted input.
  always_comb begin
    held_left  = occupancy - {1'b0, pop};
    drop_in    = {1'b0, in_valid & in_ready};
    squash_inc = {1'b0, held_left} + {1'b0, drop_in};
    cnt_sum    = {1'b0, squash_cnt} + (CNT_W+1)'(squash_inc);
    cnt_nx     = squash_cnt;
    if (flush) begin
      cnt_nx = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  // Occupancy transitions; flush forces EMPTY regardless of push/pop.
  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = TWO;
        else if (!push && pop) state_nx = EMPTY;
      end
      TWO:     if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
    if (flush) state_nx = EMPTY;
  end

  // State, registered handshake outputs and head/skid storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      occupancy  <= 2'd0;
      squash_cnt <= '0;
      out_data   <= '0;
      out_ctrl   <= '0;
      out_bad    <= 1'b0;
      s_data     <= '0;
      s_ctrl     <= '0;
      s_bad      <= 1'b0;
    end else begin
      state      <= state_nx;
      out_valid  <= (state_nx != EMPTY);
      in_ready   <= (state_nx != TWO);
      occupancy  <= state_nx;
      squash_cnt <= cnt_nx;
      if (!flush) begin
        unique case (state)
          EMPTY: begin
            if (push) begin
              out_data <= in_data;
              out_ctrl <= in_ctrl_m;
              out_bad  <= in_bad;
            end
          end
          ONE: begin
            if (push && pop) begin
              out_data <= in_data;
              out_ctrl <= in_ctrl_m;
              out_bad  <= in_bad;
            end else if (push) begin
              s_data <= in_data;
              s_ctrl <= in_ctrl_m;
              s_bad  <= in_bad;
            end
          end
          TWO: begin
            if (pop) begin
              out_data <= s_data;
              out_ctrl <= s_ctrl;
              out_bad  <= s_bad;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: ordering, masking, flush, saturation,
// asynchronous reset.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [15:0] in_ctrl;
  logic        in_bad;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [15:0] out_ctrl;
  logic        out_bad;
  logic [1:0]  occupancy;
  logic [7:0]  squash_cnt;

  int n_chk;
  int n_pass;
  int exp_cnt;

  pipe_stage_buf #(.DATA_W(64), .CTRL_W(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .in_bad     (in_bad),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_bad    (out_bad),
    .occupancy  (occupancy),
    .squash_cnt (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d,
                       input logic [15:0] c, input logic b,
                       input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    in_bad    = b;
    flush     = f;
    out_ready = r;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    exp_cnt = 0;
    rst     = 1'b0;
    drive(0, 64'h0, 16'h0, 0, 0, 0);
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_occ", occupancy, 0);
    check("rst_cnt", squash_cnt, 0);
    check("rst_data", out_data, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_bad", out_bad, 0);
    rst = 1'b1;
    step();

    // single beat, latency one cycle
    drive(1, 64'h11, 16'h1234, 0, 0, 1);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 64'h11);
    check("t1_ctrl", out_ctrl, 16'h1234);
    check("t1_occ", occupancy, 1);
    drive(0, 64'h0, 16'h0, 0, 0, 1);
    step();
    check("t1_drain", out_valid, 0);

    // fill both entries, drain in order
    drive(1, 64'h21, 16'h0001, 0, 0, 0);
    step();
    drive(1, 64'h22, 16'h0002, 0, 0, 0);
    step();
    check("t2_occ", occupancy, 2);
    check("t2_ready", in_ready, 0);
    check("t2_head0", out_data, 64'h21);
    drive(0, 64'h0, 16'h0, 0, 0, 1);
    step();
    check("t2_head1", out_data, 64'h22);
    check("t2_ctrl1", out_ctrl, 16'h0002);
    check("t2_occ1", occupancy, 1);
    check("t2_ready1", in_ready, 1);
    step();
    check("t2_occ0", occupancy, 0);

    // bad beat masks controls, keeps payload
    drive(1, 64'hABCD, 16'hFFFF, 1, 0, 0);
    step();
    check("t3_bad", out_bad, 1);
    check("t3_ctrl", out_ctrl, 16'h0000);
    check("t3_data", out_data, 64'hABCD);
    drive(0, 64'h0, 16'h0, 0, 0, 1);
    step();
    check("t3_empty", occupancy, 0);

    // simultaneous push and pop in ONE
    drive(1, 64'h31, 16'h0031, 0, 0, 0);
    step();
    drive(1, 64'h32, 16'h0032, 0, 0, 1);
    step();
    check("pp_occ", occupancy, 1);
    check("pp_data", out_data, 64'h32);
    check("pp_bad", out_bad, 0);
    drive(0, 64'h0, 16'h0, 0, 0, 1);
    step();

    // flush in TWO with incoming beat
    drive(1, 64'h41, 16'h0041, 0, 0, 0);
    step();
    drive(1, 64'h42, 16'h0042, 0, 0, 0);
    step();
    drive(1, 64'h43, 16'h0043, 0, 1, 0);
    step();
    exp_cnt = 2;
    check("t4_valid", out_valid, 0);
    check("t4_ready", in_ready, 1);
    check("t4_occ", occupancy, 0);
    check("t4_cnt", squash_cnt, exp_cnt);

    // flush in ONE: head popped, incoming dropped -> +1
    drive(1, 64'h51, 16'h0051, 0, 0, 0);
    step();
    drive(1, 64'h52, 16'h0052, 0, 1, 1);
    step();
    exp_cnt = 3;
    check("fo_cnt", squash_cnt, exp_cnt);
    check("fo_occ", occupancy, 0);

    // flush in ONE, nothing popped or incoming -> +1
    drive(1, 64'h61, 16'h0061, 0, 0, 0);
    step();
    drive(0, 64'h0, 16'h0, 0, 1, 0);
    step();
    exp_cnt = 4;
    check("fh_cnt", squash_cnt, exp_cnt);

    // climb to 0xFE in steps of two
    while (exp_cnt < 254) begin
      drive(1, 64'h71, 16'h0, 0, 0, 0);
      step();
      drive(1, 64'h72, 16'h0, 0, 0, 0);
      step();
      drive(1, 64'h73, 16'h0, 0, 1, 0);
      step();
      exp_cnt += 2;
    end
    check("t5_pre", squash_cnt, 8'hFE);

    // saturate, not wrap
    drive(1, 64'h81, 16'h0, 0, 0, 0);
    step();
    drive(1, 64'h82, 16'h0, 0, 0, 0);
    step();
    drive(1, 64'h83, 16'h0, 0, 1, 0);
    step();
    check("t5_sat", squash_cnt, 8'hFF);
    drive(1, 64'h84, 16'h0, 0, 0, 0);
    step();
    drive(1, 64'h85, 16'h0, 0, 1, 0);
    step();
    check("t5_hold", squash_cnt, 8'hFF);

    // asynchronous reset with two held
    drive(1, 64'h91, 16'h0091, 0, 0, 0);
    step();
    drive(1, 64'h92, 16'h0092, 0, 0, 0);
    step();
    check("t6_pre", occupancy, 2);
    drive(0, 64'h0, 16'h0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_occ", occupancy, 0);
    check("t6_data", out_data, 0);
    check("t6_ready", in_ready, 1);
    check("t6_cnt", squash_cnt, 0);
    #3;
    rst = 1'b1;
    step();
    check("t6_after", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
